// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and helpers for the loadable instruction memory.
//   state_e          : controller state (RUN serves fetches, LOAD accepts beats)
//   dsel_e           : which source drives the fetch_data output
//   NOP_WORD_DEFAULT : word returned for an out-of-program fetch
//   addr_width_ok()  : checks that DEPTH words are addressable with ADDR_W bits
//   idx_width()      : index width needed to address DEPTH words in the array
// -----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    // fetch_data reads zero out of reset, NOP_WORD after an out-of-range
    // fetch, and the RAM read register after an in-range fetch.
    typedef enum logic [1:0] {
        DSEL_ZERO = 2'd0,
        DSEL_NOP  = 2'd1,
        DSEL_RAM  = 2'd2
    } dsel_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    function automatic bit addr_width_ok(input int addr_w, input int depth);
        return (depth >= 1) && (longint'(depth) <= (longint'(1) << addr_w));
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_loadable_if.sv
// -----------------------------------------------------------------------------
// imem_loadable_if
// Bundles the program-load port and the fetch port of imem_loadable.
//   master : loader / fetch stage side (drives load_* and fetch_req/addr)
//   slave  : the instruction memory side
// Signals:
//   load_start, load_valid, load_data, load_last -> load beats
//   load_ready, prog_len, busy                   <- load status
//   fetch_req, fetch_addr                        -> fetch request
//   fetch_valid, fetch_data, fetch_err           <- fetch response
// -----------------------------------------------------------------------------
interface imem_loadable_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic [ADDR_W:0]   prog_len;
    logic              busy;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_err;

    modport master (
        output load_start, load_valid, load_data, load_last,
        output fetch_req, fetch_addr,
        input  load_ready, prog_len, busy,
        input  fetch_valid, fetch_data, fetch_err
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  fetch_req, fetch_addr,
        output load_ready, prog_len, busy,
        output fetch_valid, fetch_data, fetch_err
    );
endinterface

// File: rtl/imem_ram_1r1w.sv
// -----------------------------------------------------------------------------
// imem_ram_1r1w
// DEPTH x DATA_W array with one synchronous write port and one registered
// read port. The read register holds its value when re_i is low.
// Ports:
//   clk     : clock, rising edge
//   we_i    : write enable;  waddr_i / wdata_i : write address / data
//   re_i    : read enable;   raddr_i           : read address
//   rdata_o : registered read data
// -----------------------------------------------------------------------------
module imem_ram_1r1w
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // NOTE: the array and its read register carry no reset so the tools can
    // map them onto block RAM; callers must not rely on their power-up value.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
// Instruction memory with a runtime program-load port and a registered,
// bounds-checked fetch port.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset (abandons any load in progress)
//   bus : imem_loadable_if.slave
//         load side  - load_start/valid/data/last in, load_ready/prog_len/busy out
//         fetch side - fetch_req/addr in, fetch_valid/data/err out (1-cycle latency)
// Controller: RUN serves fetches; LOAD writes beats at wr_ptr until the beat
// flagged load_last or the beat that fills the last word, then publishes the
// word count in prog_len and returns to RUN.
// -----------------------------------------------------------------------------
module imem_loadable
    import imem_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input logic           clk,
    input logic           rst,
    imem_loadable_if.slave bus
);

    localparam int              IDX_W     = idx_width(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);

    if (!addr_width_ok(ADDR_W, DEPTH)) begin : g_bad_depth
        $error("imem_loadable: DEPTH must be between 1 and 2**ADDR_W");
    end

    state_e            state_q;
    logic [ADDR_W:0]   wr_ptr_q;
    logic [ADDR_W:0]   wr_ptr_d;
    logic [ADDR_W:0]   prog_len_q;
    logic              fetch_valid_q;
    dsel_e             dsel_q;

    logic              load_ready;
    logic              beat_acc;
    logic              last_beat;
    logic              fetch_acc;
    logic              in_range;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] fetch_data;

    assign load_ready = (state_q == ST_LOAD) && (wr_ptr_q < DEPTH_CNT);
    // load_start in LOAD restarts the program, so it drops a coincident beat.
    assign beat_acc   = bus.load_valid && load_ready && !bus.load_start;
    assign last_beat  = bus.load_last || (wr_ptr_q == LAST_CNT);
    assign wr_ptr_d   = wr_ptr_q + (ADDR_W + 1)'(1);

    // Fetches are served only from RUN; the bound is checked at ADDR_W+1 bits
    // so a full-depth program still compares correctly.
    assign fetch_acc  = bus.fetch_req && (state_q == ST_RUN);
    assign in_range   = ({1'b0, bus.fetch_addr} < prog_len_q);

    // Reads happen only in RUN and writes only in LOAD, so the two ports never
    // touch the array in the same cycle.
    assign ram_we     = beat_acc;
    assign ram_re     = fetch_acc && in_range;

    imem_ram_1r1w #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[IDX_W-1:0]),
        .wdata_i (bus.load_data),
        .re_i    (ram_re),
        .raddr_i (bus.fetch_addr[IDX_W-1:0]),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wr_ptr_q      <= '0;
            prog_len_q    <= '0;
            fetch_valid_q <= 1'b0;
            dsel_q        <= DSEL_ZERO;
        end else begin
            fetch_valid_q <= fetch_acc;
            // The data source changes only on an accepted fetch, which keeps
            // fetch_data stable while fetch_valid is low.
            if (fetch_acc) begin
                dsel_q <= in_range ? DSEL_RAM : DSEL_NOP;
            end

            case (state_q)
                ST_RUN: begin
                    if (bus.load_start) begin
                        state_q    <= ST_LOAD;
                        wr_ptr_q   <= '0;
                        prog_len_q <= '0;
                    end
                end
                ST_LOAD: begin
                    if (bus.load_start) begin
                        wr_ptr_q   <= '0;
                        prog_len_q <= '0;
                    end else if (beat_acc) begin
                        wr_ptr_q <= wr_ptr_d;
                        if (last_beat) begin
                            state_q    <= ST_RUN;
                            prog_len_q <= wr_ptr_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        fetch_data = '0;
        case (dsel_q)
            DSEL_NOP:  fetch_data = NOP_WORD;
            DSEL_RAM:  fetch_data = ram_rdata;
            default:   fetch_data = '0;
        endcase
    end

    assign bus.load_ready  = load_ready;
    assign bus.prog_len    = prog_len_q;
    assign bus.busy        = (state_q == ST_LOAD);
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data;
    assign bus.fetch_err   = fetch_valid_q && (dsel_q == DSEL_NOP);

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Next-generation instruction memory for the MIPS32 core.
- Parametrised in address width, data width and depth.
- Replaces a fixed-content ROM with a runtime program-load port.
- Fetch port is registered with a one-cycle request/valid handshake, bounds-checked against the loaded program length; out-of-program fetches return a NOP word plus an error flag.
- Sits between the PC/fetch stage and an external program loader (testbench or UART boot block).

Parameters:
- ADDR_W, 8: fetch/load address width in words.
- DATA_W, 32: instruction word width.
- DEPTH, 256: number of words; must satisfy DEPTH <= 2**ADDR_W.
- NOP_WORD, 32'h0000_0000: word returned on an out-of-range fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  enter LOAD state; clears write pointer and program length.
- load_valid  in  1  load beat valid.
- load_data  in  DATA_W  instruction word to store.
- load_last  in  1  qualifies the final beat of a program.
- load_ready  out  1  block accepts a load beat this cycle.
- prog_len  out  ADDR_W+1  number of valid words in the current program.
- busy  out  1  high while in LOAD.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  word address to fetch.
- fetch_valid  out  1  response valid; exactly one cycle after an accepted request.
- fetch_data  out  DATA_W  fetched instruction.
- fetch_err  out  1  response addressed at or beyond prog_len.

Behaviour:
- Reset values: state = RUN, wr_ptr = 0, prog_len = 0, load_ready = 0, busy = 0, fetch_valid = 0, fetch_data = 0, fetch_err = 0. Memory array is not reset.
- Reset has priority over every other input in the same cycle.
- A reset during LOAD abandons the load. prog_len = 0, so every subsequent fetch errors until a new load completes.
- FSM has two states, RUN and LOAD.
  - RUN -> LOAD on load_start.
  - LOAD -> LOAD on load_start: pointer restarts at 0 and prog_len is set to 0.
  - LOAD -> RUN on an accepted beat with load_last = 1, or on an accepted beat that fills word DEPTH-1.
- load_ready = (state == LOAD) and (wr_ptr < DEPTH), as a combinational function of registered state.
- Accepted beat = load_valid & load_ready. It writes mem[wr_ptr] = load_data and sets wr_ptr = wr_ptr + 1.
  - On the transition to RUN, prog_len = wr_ptr + 1 (the post-increment count).
  - While in LOAD, prog_len reads 0.
- load_valid with load_ready = 0 is ignored; no write occurs and no state change occurs.
- Simultaneous load_start and load_valid in LOAD: load_start wins, the beat is dropped, and wr_ptr = 0.
- Fetch acceptance: a fetch is accepted iff fetch_req = 1 and state == RUN in that cycle.
  - A fetch in the same cycle as load_start from RUN is still accepted and answered.
  - Fetches during LOAD are dropped: fetch_valid = 0 next cycle.
- Fetch latency is 1 cycle. A request accepted in cycle N gives fetch_valid = 1 in cycle N+1 with:
  - if fetch_addr < prog_len (compared at ADDR_W+1 bits): fetch_data = mem[fetch_addr], fetch_err = 0;
  - otherwise: fetch_data = NOP_WORD, fetch_err = 1.
- Back-to-back requests are allowed every cycle; there is no backpressure on the fetch side.
- When fetch_valid = 0, fetch_data holds its last value and fetch_err = 0.
- Read/write collision cannot occur, because reads happen only in RUN and writes only in LOAD.

Decomposition:
- Shared package imem_pkg:
  - state enum {ST_RUN, ST_LOAD};
  - default NOP_WORD constant;
  - function for the address-width check (DEPTH <= 2**ADDR_W), used by an elaboration-time assertion.
- One natural sub-module: imem_ram_1r1w, a simple synchronous-write, registered-read DEPTH x DATA_W array (no reset), so that it maps to block RAM.
- The FSM, pointer, length and bounds logic stay in the top module.

Test Plan:
1. Reset, then fetch addr 0 -> one cycle later fetch_valid = 1, fetch_data = 0x00000000, fetch_err = 1, prog_len = 0.
2. load_start; stream 4 beats 0x0C010003, 0x04010004, 0x0C010008, 0x04010005, with load_last on the 4th -> busy drops, prog_len = 4. Fetch addrs 0..3 back-to-back -> the 4 words in order, each 1 cycle after its request, fetch_err = 0.
3. After test 2, fetch addr 4 and addr 255 -> fetch_data = NOP_WORD, fetch_err = 1. Fetch addr 3 -> 0x04010005, fetch_err = 0.
4. With DEPTH = 8, load 10 beats without load_last:
   - 8 words are written and the block auto-returns to RUN with prog_len = 8;
   - load_ready = 0 after the 8th beat;
   - beats 9-10 are ignored, and mem[0] still equals the 1st word.
5. Mid-load (2 of 5 beats accepted), assert rst -> state RUN, prog_len = 0. Fetch addr 0 -> fetch_err = 1.
6. In LOAD, issue fetch_req -> no fetch_valid. In RUN, assert load_start and fetch_req same cycle -> fetch answered next cycle, busy = 1. In LOAD, load_start together with load_valid -> beat dropped, wr_ptr = 0.
